// File: rtl/fetch_pkg.sv
// fetch_pkg: sequencer state, branch target modes and the branch target LUT contents
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  typedef enum logic [1:0] {TGT_REL_IMM, TGT_REL_LUT, TGT_ABS_LUT, TGT_RSVD} tgt_t;
  localparam int TGT_LUT [16] = '{0: -5, 1: 20, 2: -1, default: 0};
endpackage

// File: rtl/branch_target_lut.sv
// branch_target_lut: maps a 4-bit index to a D-bit branch target or offset
module branch_target_lut import fetch_pkg::*; #(
  parameter int D = 12
) (
  input  logic [3:0]   lut_idx,
  output logic [D-1:0] val
);
  assign val = D'(TGT_LUT[lut_idx]);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer with start/halt/stall/branch control and run-cycle counter
module fetch_sequencer import fetch_pkg::*; #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          halt,
  input  logic          stall,
  input  logic          br_take,
  input  logic [1:0]    tgt_sel,
  input  logic [7:0]    imm,
  input  logic [3:0]    lut_idx,
  output logic [D-1:0]  pc,
  output logic          fetch_en,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);
  state_t state;
  tgt_t mode;
  logic [D-1:0] lut_val, tgt;
  branch_target_lut #(.D(D)) u_lut (.lut_idx(lut_idx), .val(lut_val));
  always_comb begin
    mode = tgt_t'(tgt_sel);
    tgt = mode == TGT_ABS_LUT ? lut_val : pc + (mode == TGT_REL_LUT ? lut_val : {{(D-8){imm[7]}}, imm});
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      fetch_en <= 1'b0;
      done <= 1'b0;
      cycle_cnt <= '0;
    end else if (start) begin
      state <= RUN;
      pc <= '0;
      fetch_en <= 1'b1;
      done <= 1'b0;
      cycle_cnt <= '0;
    end else if (state == RUN) begin
      cycle_cnt <= cycle_cnt + CW'(cycle_cnt != '1);
      if (halt) begin
        state <= HALTED;
        fetch_en <= 1'b0;
        done <= 1'b1;
      end else if (!stall) begin
        pc <= br_take ? tgt : pc + 1'b1;
      end
    end
  end
endmodule
